// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: the FSM state encoding and the reset values.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam cnt_state_t STATE_RESET = IDLE;
    localparam logic       DONE_RESET  = 1'b0;

endpackage

// File: rtl/down_count_core.sv
// Datapath for the down counter: a WIDTH-bit register that can be loaded, decremented or held,
// plus detection of the terminal value q==1.
module down_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             terminal
);

    // Load has priority over decrement. The count saturates at zero, so it never wraps around.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec && (q != '0)) begin
            q <= q - WIDTH'(1);
        end
    end

    assign terminal = (q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter: FSM, reload register, done/busy/bco around down_count_core.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN (periodic reload on terminal count instead of one-shot).
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             bco
);

    cnt_state_t       state, state_next;
    logic [WIDTH-1:0] reload, reload_next;
    logic             done_next;
    logic             core_load;
    logic [WIDTH-1:0] core_val;
    logic             core_dec;
    logic             terminal;

    down_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .dec      (core_dec),
        .q        (q),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= STATE_RESET;
            reload <= '0;
            done   <= DONE_RESET;
        end else begin
            state  <= state_next;
            reload <= reload_next;
            done   <= done_next;
        end
    end

    // Priority is load > abort > en. A load of zero finishes immediately without entering RUN.
    always_comb begin
        state_next  = state;
        reload_next = reload;
        done_next   = 1'b0;
        core_load   = 1'b0;
        core_val    = load_val;
        core_dec    = 1'b0;
        if (load) begin
            core_load   = 1'b1;
            reload_next = load_val;
            if (load_val != '0) begin
                state_next = RUN;
            end else begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (en) begin
                        if (terminal) begin
                            done_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            core_load = 1'b1;
                            core_val  = reload;
`else
                            core_dec   = 1'b1;
                            state_next = DONE;
`endif
                        end else begin
                            core_dec = 1'b1;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign bco  = (state == RUN) && en && terminal;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a directed vector table plus hand-written reset and latency sequences.
module tb_countdown_timer;

    localparam int WIDTH = 8;

    typedef struct {
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] load_val;
        logic             en;
        logic             abort;
        logic             exp_bco;
        logic [WIDTH-1:0] exp_q;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             bco;

    int   vectors = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .abort    (abort),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .bco      (bco)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic ld, input int lv, input logic e,
                                input logic ab, input logic xbco, input int xq,
                                input logic xbusy, input logic xdone);
        vec_t v;
        v.rst = r; v.load = ld; v.load_val = WIDTH'(lv); v.en = e; v.abort = ab;
        v.exp_bco = xbco; v.exp_q = WIDTH'(xq); v.exp_busy = xbusy; v.exp_done = xdone;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic ld, input logic [WIDTH-1:0] lv,
                                 input logic e, input logic ab);
        rst = r; load = ld; load_val = lv; en = e; abort = ab;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        int cycles;
        bit seen;

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Reset with random inputs for two edges: rst must win over everything.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 1'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end
        @(posedge clk); #1;
        checkOutput("reset q", 32'(q), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset bco", 32'(bco), 0);

        //   rst ld lv  en ab | bco q  busy done
`ifdef COUNTDOWN_AUTORELOAD_EN
        add(1, 1,   2, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   2, 1, 1);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   2, 1, 1);
        add(1, 0,   0, 0, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 0, 1,   0,   1, 0, 0);
        add(1, 0,   0, 1, 0,   0,   1, 0, 0);
        add(1, 1,   0, 0, 0,   0,   0, 0, 1);
        add(1, 0,   0, 0, 0,   0,   0, 0, 0);
        add(1, 1,   3, 1, 0,   0,   3, 1, 0);
        add(1, 0,   0, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   3, 1, 1);
        add(1, 1,   1, 0, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   1, 1, 1);
        add(1, 0,   0, 1, 0,   1,   1, 1, 1);
        add(1, 0,   0, 1, 1,   1,   1, 0, 0);
        add(1, 1, 255, 1, 0,   0, 255, 1, 0);
        add(1, 0,   0, 1, 0,   0, 254, 1, 0);
        add(0, 0,   0, 1, 0,   0,   0, 0, 0);
`else
        // Load 3 with en steady.
        add(1, 1,   3, 1, 0,   0,   3, 1, 0);
        add(1, 0,   0, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   0, 0, 1);
        add(1, 0,   0, 1, 0,   0,   0, 0, 0);
        // Load 5 with en alternating.
        add(1, 1,   5, 0, 0,   0,   5, 1, 0);
        add(1, 0,   0, 1, 0,   0,   4, 1, 0);
        add(1, 0,   0, 0, 0,   0,   4, 1, 0);
        add(1, 0,   0, 1, 0,   0,   3, 1, 0);
        add(1, 0,   0, 0, 0,   0,   3, 1, 0);
        add(1, 0,   0, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 0, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 0, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   0, 0, 1);
        add(1, 0,   0, 0, 0,   0,   0, 0, 0);
        // Reload mid-run.
        add(1, 1,   4, 1, 0,   0,   4, 1, 0);
        add(1, 0,   0, 1, 0,   0,   3, 1, 0);
        add(1, 0,   0, 1, 0,   0,   2, 1, 0);
        add(1, 1,   2, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   0, 0, 1);
        add(1, 0,   0, 0, 0,   0,   0, 0, 0);
        // Load coinciding with the terminal decrement gives no done.
        add(1, 1,   2, 1, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 0,   0,   1, 1, 0);
        add(1, 1,   3, 1, 0,   1,   3, 1, 0);
        add(1, 0,   0, 0, 1,   0,   3, 0, 0);
        // Load zero, abort, en ignored in IDLE.
        add(1, 1,   0, 0, 0,   0,   0, 0, 1);
        add(1, 0,   0, 0, 0,   0,   0, 0, 0);
        add(1, 1,   2, 0, 0,   0,   2, 1, 0);
        add(1, 0,   0, 1, 1,   0,   2, 0, 0);
        add(1, 0,   0, 1, 0,   0,   2, 0, 0);
        add(1, 0,   0, 0, 1,   0,   2, 0, 0);
        // Load beats abort; en in DONE is ignored.
        add(1, 1,   1, 0, 1,   0,   1, 1, 0);
        add(1, 0,   0, 1, 0,   1,   0, 0, 1);
        add(1, 0,   0, 1, 0,   0,   0, 0, 0);
        // Full range, then reset mid-run.
        add(1, 1, 255, 1, 0,   0, 255, 1, 0);
        add(1, 0,   0, 1, 0,   0, 254, 1, 0);
        add(1, 0,   0, 0, 1,   0, 254, 0, 0);
        add(1, 1,   3, 0, 0,   0,   3, 1, 0);
        add(0, 0,   0, 1, 0,   0,   0, 0, 0);
        add(1, 1,   1, 0, 0,   0,   1, 1, 0);
        add(0, 1,   7, 1, 0,   1,   0, 0, 0);
        add(1, 0,   0, 1, 0,   0,   0, 0, 0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].abort);
            #1;
            checkOutput($sformatf("v%0d bco", i), 32'(bco), 32'(vecs[i].exp_bco));
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d q", i), 32'(q), 32'(vecs[i].exp_q));
            checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].exp_done));
        end

        // Latency: done must appear exactly 6 enabled cycles after loading 6.
        applyStimulus(1'b1, 1'b1, WIDTH'(6), 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        cycles = 0;
        seen = 0;
        while (!seen && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1;
        end
        checkOutput("latency done seen", 32'(seen), 1);
        checkOutput("latency cycles", 32'(cycles), 6);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("final busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
